// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the frame width, the default 50 MHz / 9600 baud bit period and the FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_BIT_CYCLES = 5208;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input that idles high.
// Both flops reset to 1 so a released reset never looks like a falling edge.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle valid strobe per good frame.
// A low stop bit raises frame_err and the line must return high before the next frame is accepted.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES  = UART_BIT_CYCLES,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err
);

  localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
  localparam int IDX_W = $clog2(UART_DATA_W);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_W - 1);

  logic rxd_s;

  uart_state_e            state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [UART_DATA_W-1:0] shift_q,     shift_d;
  logic [UART_DATA_W-1:0] rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The shift register is pure data; a discarded partial byte never reaches rx_data.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end

      // Re-check the start bit at its centre so short glitches are ignored.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid-stop-bit leaves half a bit of slack to catch an immediate next start.
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: a fast instance (16 cycles/bit) for directed frames and a
// default-rate instance fed by a transmitter model running 5209 cycles/bit.
module tb_uart_rx_8n1;
  import uart_pkg::*;

  localparam int BITC    = 16;
  localparam int SLOW_TX = 5209;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, rxd = 1'b1;
  logic       rst_slow = 1'b1, rxd_slow = 1'b1;
  logic [7:0] rx_data, rx_data_s;
  logic       rx_valid, frame_err, rx_valid_s, frame_err_s;

  uart_rx_8n1 #(.BIT_CYCLES(BITC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  uart_rx_8n1 dut_slow (
    .clk       (clk),
    .rst       (rst_slow),
    .rxd       (rxd_slow),
    .rx_data   (rx_data_s),
    .rx_valid  (rx_valid_s),
    .frame_err (frame_err_s)
  );

  exp_t       exp_q[$];
  exp_t       exp_s_q[$];
  exp_t       e, es;
  int         errors = 0;
  int         checks = 0;
  logic       rst_seen = 1'b0;
  logic       done = 1'b0;
  logic [7:0] model_last = 8'h00;
  logic [7:0] model_last_s = 8'h00;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rst_seen <= rst;

  // Monitor: pops the scoreboard on every output pulse and checks rx_data holds otherwise.
  always @(negedge clk) begin
    if (done) begin
      check8("pending_fast", 8'(exp_q.size()), 8'h00);
      check8("pending_slow", 8'(exp_s_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else begin
      if (rst_seen) begin
        check8("reset_rx_data", rx_data, 8'h00);
        check8("reset_rx_valid", {7'b0, rx_valid}, 8'h00);
        check8("reset_frame_err", {7'b0, frame_err}, 8'h00);
        model_last = 8'h00;
      end else begin
        check8("valid_err_exclusive", {7'b0, rx_valid & frame_err}, 8'h00);
        if (rx_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            check8("unexpected_pulse", {6'b0, rx_valid, frame_err}, 8'h00);
          end else begin
            e = exp_q.pop_front();
            check8("pulse_kind_frame_err", {7'b0, frame_err}, {7'b0, e.is_err});
            check8("pulse_rx_data", rx_data, e.data);
            if (!e.is_err) model_last = e.data;
          end
        end else begin
          check8("rx_data_hold", rx_data, model_last);
        end
      end

      if (rx_valid_s || frame_err_s) begin
        if (exp_s_q.size() == 0) begin
          check8("slow_unexpected_pulse", {6'b0, rx_valid_s, frame_err_s}, 8'h00);
        end else begin
          es = exp_s_q.pop_front();
          check8("slow_frame_err", {7'b0, frame_err_s}, {7'b0, es.is_err});
          check8("slow_rx_data", rx_data_s, es.data);
          if (!es.is_err) model_last_s = es.data;
        end
      end else begin
        check8("slow_rx_data_hold", rx_data_s, model_last_s);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(BITC);
    end
    rxd = stop_bit;
    tick(BITC);
  endtask

  task automatic fast_seq();
    logic [7:0] partial;
    // Single frame 0x12
    exp_q.push_back('{1'b0, 8'h12});
    send_frame(8'h12, 1'b1);
    tick(BITC);
    // Back-to-back frames with no idle gap
    exp_q.push_back('{1'b0, 8'hA5});
    exp_q.push_back('{1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'hFF});
    send_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(BITC);
    // Short low glitch: no output expected
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(3 * BITC);
    // Low stop bit, line held low, then a good frame; rx_data keeps 0xFF at the error
    exp_q.push_back('{1'b1, 8'hFF});
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    tick(100);
    rxd = 1'b1;
    tick(BITC);
    exp_q.push_back('{1'b0, 8'h55});
    send_frame(8'h55, 1'b1);
    tick(BITC);
    // Reset during bit 4 of 0x81, then 0x42
    partial = 8'h81;
    rxd = 1'b0;
    tick(BITC);
    for (int i = 0; i < 4; i++) begin
      rxd = partial[i];
      tick(BITC);
    end
    rxd = partial[4];
    tick(BITC / 2);
    rst = 1'b1;
    rxd = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2 * BITC);
    exp_q.push_back('{1'b0, 8'h42});
    send_frame(8'h42, 1'b1);
    tick(BITC);
  endtask

  task automatic slow_seq();
    logic [7:0] d;
    d = 8'h12;
    tick(5);
    exp_s_q.push_back('{1'b0, 8'h12});
    rxd_slow = 1'b0;
    tick(SLOW_TX);
    for (int i = 0; i < 8; i++) begin
      rxd_slow = d[i];
      tick(SLOW_TX);
    end
    rxd_slow = 1'b1;
    tick(SLOW_TX);
  endtask

  initial begin
    tick(3);
    rst      = 1'b0;
    rst_slow = 1'b0;
    tick(2);
    fork
      fast_seq();
      slow_seq();
    join
    tick(40);
    done = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
